assoc_data_cache: RTL and testbench
===================================

ASSOC_DATA_CACHE -- requirements
Module: assoc_data_cache

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_WIDTH, default 32, byte address width.
- DATA_WIDTH, default 32, word width; one word per line.
- SETS, default 64, number of sets; power of two.
- WAYS, default 4, associativity; power of two, 1..16.
- WRITE_BACK, default 0; 0 = write-through/no-allocate, 1 = write-back/write-allocate.

REQ-002 The block SHALL have one clock, clk, and an asynchronous, active-high reset, reset; all other ports are synchronous to the rising edge of clk. Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- cpu_req  in  1  request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  byte address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_ready  out  1  block can accept a request
- cpu_rdata  out  DATA_WIDTH  read data
- cpu_done  out  1  one-cycle completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_ack  in  1  memory completion pulse
- hit  out  1  lookup result, qualified by cpu_done

Function
REQ-003 The block SHALL decode cpu_addr into an offset of bits [1:0] (ignored), an index of log2(SETS) bits above the offset, and a tag made of all remaining upper bits.
REQ-004 The block SHALL hold a valid bit and a tag for every line, and additionally a dirty bit when WRITE_BACK=1.
REQ-005 The block SHALL have a state machine with the states IDLE, LOOKUP, EVICT, FILL, WRMEM and RESPOND; reset enters IDLE.
REQ-006 cpu_ready SHALL be 1 only in IDLE; a request is accepted when cpu_req=1 and cpu_ready=1, and its address, data and we are registered on acceptance.
REQ-007 IDLE SHALL go to LOOKUP on acceptance and otherwise stay in IDLE.
REQ-008 In LOOKUP, a hit is the registered tag matching the tag of any valid way in the indexed set; at most one way can match.
REQ-009 A read hit SHALL assert cpu_done and hit=1 in the LOOKUP cycle, with cpu_rdata set to the line data, and return to IDLE; the completion latency is 1 cycle after acceptance.
REQ-010 A write hit with WRITE_BACK=1 SHALL update the line, set its dirty bit, assert cpu_done with hit=1 in the LOOKUP cycle, and return to IDLE.
REQ-011 A write hit with WRITE_BACK=0 SHALL update the line and go to WRMEM.
REQ-012 A write miss with WRITE_BACK=0 SHALL go to WRMEM without allocating a line.
REQ-013 WRMEM SHALL drive mem_req=1, mem_we=1 and the registered address and data until mem_ack, then go to RESPOND.
REQ-014 A read miss, or a write miss with WRITE_BACK=1, SHALL select a victim: the lowest-numbered invalid way, otherwise the set's round-robin pointer.
REQ-015 If the victim is valid and dirty, the block SHALL go to EVICT; otherwise it SHALL go to FILL.
REQ-016 EVICT SHALL write the victim's data to mem_addr = {victim tag, index, 2'b00}, holding mem_req until mem_ack, then go to FILL.
REQ-017 FILL SHALL read the registered address with mem_we=0, holding mem_req until mem_ack.
REQ-018 On mem_ack in FILL, the block SHALL install the line with valid=1 and the new tag.
REQ-019 On a write-allocate fill, the block SHALL merge cpu_wdata into the installed line and set dirty=1.
REQ-020 After a fill, the block SHALL advance the set's round-robin pointer modulo WAYS and go to RESPOND.
REQ-021 RESPOND SHALL assert cpu_done for one cycle with hit=0 (hit=1 after a write-through hit) and return to IDLE.
REQ-022 cpu_done SHALL be high for exactly one cycle per accepted request; cpu_rdata SHALL hold its value until the next read completes.
REQ-023 The round-robin pointer SHALL wrap from WAYS-1 to 0.
REQ-024 With WAYS=1 the block SHALL behave as a direct-mapped cache.
REQ-025 cpu_req while cpu_ready=0 SHALL be ignored, with no queuing.
REQ-026 mem_ack outside EVICT, FILL and WRMEM SHALL be ignored.
REQ-027 mem_req SHALL never be asserted in two consecutive transactions without a deassert cycle between them.

Reset
REQ-028 Reset SHALL clear all valid bits, dirty bits and round-robin pointers and force the state to IDLE.
REQ-029 Reset SHALL force these output values: cpu_ready=1 after release, cpu_done=0, hit=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset asserted mid-transaction SHALL abort it: mem_req drops asynchronously, no cpu_done is issued, and any partial line install is discarded.

Structure
REQ-031 The package cache_pkg SHALL hold the state enumeration and the parameter-check helper functions (log2 and power-of-two check).
REQ-032 Victim selection SHALL be a sub-module, cache_victim_sel, taking the valid vector and the round-robin pointer and returning the way index.
REQ-033 The data, tag and valid arrays SHALL be plain registers, written only in LOOKUP (write hit) or at the FILL mem_ack.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Cold read of 0x0000_0100, memory returns 0xDEADBEEF -> one FILL, cpu_done with hit=0 and rdata=0xDEADBEEF; a repeat read gives hit=1, done 1 cycle after acceptance, mem_req never rises.
- WAYS=4: read five addresses mapping to the same set -> the fifth evicts way 0, and the pointer then reads 1.
- WRITE_BACK=1: write 0x11 to A, then read four conflicting addresses -> EVICT writes 0x11 to A before the fill.
- WRITE_BACK=0: write miss of 0x55 to B -> mem_we=1 with mem_wdata=0x55; a following read of B misses.
- Reset asserted during FILL with mem_ack pending -> mem_req=0 immediately, no cpu_done, and a later read of the same address misses.
- cpu_req held high for 10 cycles during a miss -> exactly one request accepted and one cpu_done pulse.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative data cache.
// Controller states and elaboration-time parameter helpers.
package cache_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_LOOKUP  = 3'd1;
    localparam state_t S_EVICT   = 3'd2;
    localparam state_t S_FILL    = 3'd3;
    localparam state_t S_WRMEM   = 3'd4;
    localparam state_t S_RESPOND = 3'd5;

    function automatic int log2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection for one set.
// Fills empty ways first, then rotates through a full set.
module cache_victim_sel #(
    parameter int WAYS  = 4,
    parameter int WAY_W = 2
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [WAY_W-1:0] rr_ptr,
    output logic [WAY_W-1:0] way
);

    // Lowest-numbered invalid way wins; a full set uses the pointer.
    always_comb begin
        way = rr_ptr;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[w]) way = WAY_W'(w);
    end

endmodule

// File: rtl/assoc_data_cache.sv
// Set-associative single-word-line data cache.
// Write-through/no-allocate or write-back/write-allocate by parameter.
module assoc_data_cache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64,
    parameter int WAYS       = 4,
    parameter int WRITE_BACK = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  hit
);

    localparam int IDX_W = log2_f(SETS);
    localparam int WAY_W = (WAYS > 1) ? log2_f(WAYS) : 1;
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

    generate
        if (!is_pow2(SETS) || SETS < 2) begin : g_bad_sets
            $error("SETS must be a power of two >= 2");
        end
        if (!is_pow2(WAYS) || WAYS > 16) begin : g_bad_ways
            $error("WAYS must be a power of two in 1..16");
        end
    endgenerate

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic                  req_we_q;
    logic [WAY_W-1:0]      vic_q;
    logic                  gap_q;
    logic                  wt_hit_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [WAY_W-1:0]      rr_q    [SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [WAYS-1:0]  set_valid;
    logic [WAYS-1:0]  set_dirty;
    logic [WAY_W-1:0] rr_cur;
    logic [WAY_W-1:0] vic_way;
    logic [WAY_W-1:0] hit_way;
    logic             hit_any;
    logic             in_lookup;
    logic             rd_hit;
    logic             wr_hit;
    logic             fast_done;
    logic             ack;
    logic             fill_ack;

    assign idx       = req_addr_q[IDX_W+1:2];
    assign tag       = req_addr_q[ADDR_WIDTH-1:IDX_W+2];
    assign set_valid = valid_q[idx];
    assign set_dirty = dirty_q[idx];
    assign rr_cur    = rr_q[idx];

    cache_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim (
        .valid  (set_valid),
        .rr_ptr (rr_cur),
        .way    (vic_way)
    );

    // Tag compare across the indexed set.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (set_valid[w] && tag_q[idx][w] == tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign in_lookup = (state_q == S_LOOKUP);
    assign rd_hit    = in_lookup && hit_any && !req_we_q;
    assign wr_hit    = in_lookup && hit_any && req_we_q;
    assign fast_done = rd_hit || (wr_hit && WRITE_BACK != 0);
    assign ack       = mem_ack && mem_req;
    assign fill_ack  = (state_q == S_FILL) && ack;

    assign cpu_ready = (state_q == S_IDLE);
    assign cpu_done  = fast_done || (state_q == S_RESPOND);
    assign hit       = fast_done || ((state_q == S_RESPOND) && wt_hit_q);
    assign cpu_rdata = rd_hit ? data_q[idx][hit_way] : rdata_q;

    // Memory port decode; gap_q forces an idle cycle between EVICT and FILL.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_EVICT: begin
                mem_req   = !gap_q;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[idx][vic_q], idx, 2'b00};
                mem_wdata = data_q[idx][vic_q];
            end
            S_FILL: begin
                mem_req  = !gap_q;
                mem_addr = req_addr_q;
            end
            S_WRMEM: begin
                mem_req   = !gap_q;
                mem_we    = 1'b1;
                mem_addr  = req_addr_q;
                mem_wdata = req_wdata_q;
            end
            default: ;
        endcase
    end

    // Controller plus per-line valid/dirty bits and round-robin pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_we_q    <= 1'b0;
            vic_q       <= '0;
            gap_q       <= 1'b0;
            wt_hit_q    <= 1'b0;
            rdata_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            gap_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        req_addr_q  <= cpu_addr;
                        req_wdata_q <= cpu_wdata;
                        req_we_q    <= cpu_we;
                        state_q     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    wt_hit_q <= hit_any && req_we_q && (WRITE_BACK == 0);
                    if (hit_any) begin
                        if (!req_we_q) begin
                            rdata_q <= data_q[idx][hit_way];
                            state_q <= S_IDLE;
                        end else if (WRITE_BACK != 0) begin
                            dirty_q[idx][hit_way] <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_WRMEM;
                        end
                    end else if (req_we_q && WRITE_BACK == 0) begin
                        state_q <= S_WRMEM;
                    end else begin
                        vic_q   <= vic_way;
                        state_q <= (set_valid[vic_way] && set_dirty[vic_way])
                                   ? S_EVICT : S_FILL;
                    end
                end
                S_EVICT: begin
                    if (ack) begin
                        gap_q   <= 1'b1;
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (ack) begin
                        valid_q[idx][vic_q] <= 1'b1;
                        dirty_q[idx][vic_q] <= (WRITE_BACK != 0) && req_we_q;
                        rr_q[idx] <= (rr_cur == WAY_W'(WAYS - 1))
                                     ? '0 : rr_cur + 1'b1;
                        if (!req_we_q) rdata_q <= mem_rdata;
                        state_q <= S_RESPOND;
                    end
                end
                S_WRMEM: begin
                    if (ack) state_q <= S_RESPOND;
                end
                S_RESPOND: state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    // Line storage: write-hit update in LOOKUP, install at the fill ack.
    always_ff @(posedge clk) begin
        if (wr_hit)
            data_q[idx][hit_way] <= req_wdata_q;
        if (fill_ack) begin
            data_q[idx][vic_q] <= req_we_q ? req_wdata_q : mem_rdata;
            tag_q[idx][vic_q]  <= tag;
        end
    end

endmodule

// File: tb/tb_assoc_data_cache.sv
// Bench for assoc_data_cache: one write-through and one write-back
// instance, a behavioural memory, and a done-driven scoreboard.
module tb_assoc_data_cache;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       reset = 2'b11;
    logic [1:0]       cpu_req = '0;
    logic [1:0]       cpu_we = '0;
    logic [1:0][31:0] cpu_addr = '0;
    logic [1:0][31:0] cpu_wdata = '0;
    logic [1:0]       cpu_ready;
    logic [1:0][31:0] cpu_rdata;
    logic [1:0]       cpu_done;
    logic [1:0]       mem_req;
    logic [1:0]       mem_we;
    logic [1:0][31:0] mem_addr;
    logic [1:0][31:0] mem_wdata;
    logic [1:0][31:0] mem_rdata = '0;
    logic [1:0]       mem_ack = '0;
    logic [1:0]       hit;

    assoc_data_cache #(.WRITE_BACK(0)) dut_wt (
        .clk(clk), .reset(reset[0]),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]),
        .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_ready(cpu_ready[0]), .cpu_rdata(cpu_rdata[0]),
        .cpu_done(cpu_done[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0]),
        .hit(hit[0])
    );

    assoc_data_cache #(.WRITE_BACK(1)) dut_wb (
        .clk(clk), .reset(reset[1]),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]),
        .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_ready(cpu_ready[1]), .cpu_rdata(cpu_rdata[1]),
        .cpu_done(cpu_done[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1]),
        .hit(hit[1])
    );

    typedef struct {
        int          inst;
        bit          hit;
        bit          chk;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    typedef struct {
        int          inst;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } mtx_t;

    exp_t        sb[$];
    mtx_t        mlog[$];
    logic [31:0] mem [bit [32:0]];
    int          mlat[2];
    bit          stall[2];
    int          cnt[2];
    int          reqrise[2];
    bit          req_prev[2];
    int          donecnt[2];
    int          checks = 0;
    int          errors = 0;

    function automatic bit [32:0] key(input int d, input logic [31:0] a);
        return {d[0], a};
    endfunction

    // Memory model: acks after mlat[d] cycles of mem_req, logs every access.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_req[d] && !req_prev[d]) reqrise[d]++;
            req_prev[d] = mem_req[d];
            if (mem_ack[d]) begin
                mem_ack[d] <= 1'b0;
                cnt[d] = 0;
            end else if (mem_req[d] && !stall[d]) begin
                cnt[d]++;
                if (cnt[d] >= mlat[d]) begin
                    mtx_t t;
                    cnt[d] = 0;
                    mem_ack[d] <= 1'b1;
                    t.inst = d;
                    t.we   = mem_we[d];
                    t.addr = mem_addr[d];
                    t.data = mem_wdata[d];
                    if (mem_we[d]) begin
                        mem[key(d, mem_addr[d])] = mem_wdata[d];
                    end else begin
                        t.data = mem.exists(key(d, mem_addr[d]))
                                 ? mem[key(d, mem_addr[d])] : 32'h0;
                        mem_rdata[d] <= t.data;
                    end
                    mlog.push_back(t);
                end
            end else begin
                cnt[d] = 0;
            end
        end
    end

    // Monitor: every cpu_done pops one expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cpu_done[d]) begin
                donecnt[d]++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected inst %0d hit %0b rdata %h",
                             d, hit[d], cpu_rdata[d]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.inst != d || e.hit != hit[d] ||
                        (e.chk && e.rdata !== cpu_rdata[d])) begin
                        errors++;
                        $display("FAIL %s inst %0d hit %0b rdata %h, expected inst %0d hit %0b rdata %h",
                                 e.name, d, hit[d], cpu_rdata[d],
                                 e.inst, e.hit, e.rdata);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_log(input string nm, input int i, input bit we,
                           input logic [31:0] a, input logic [31:0] dt);
        mtx_t t;
        checks++;
        if (i >= mlog.size()) begin
            errors++;
            $display("FAIL %s no memory access %0d (log size %0d)",
                     nm, i, mlog.size());
        end else begin
            t = mlog[i];
            if (t.we != we || t.addr !== a || t.data !== dt) begin
                errors++;
                $display("FAIL %s got we %0b addr %h data %h expected we %0b addr %h data %h",
                         nm, t.we, t.addr, t.data, we, a, dt);
            end
        end
    endtask

    task automatic req(input int d, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input bit eh, input bit ck,
                       input logic [31:0] er, input string nm,
                       output int lat);
        exp_t e;
        int   n;
        e.inst = d; e.hit = eh; e.chk = ck; e.rdata = er; e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        n = 0;
        while (!cpu_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        cpu_req[d] = 1'b1; cpu_we[d] = we;
        cpu_addr[d] = a;   cpu_wdata[d] = wd;
        @(negedge clk);
        cpu_req[d] = 1'b0;
        lat = 1;
        while (!cpu_done[d] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!cpu_done[d]) begin
            checks++;
            errors++;
            $display("FAIL %s timeout no cpu_done after %0d cycles", nm, lat);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r0;
        int dc;
        int acc;
        int n;
        mlat[0] = 2; mlat[1] = 2;
        stall[0] = 0; stall[1] = 0;
        mem[key(0, 32'h0000_0100)] = 32'hDEAD_BEEF;
        mem[key(0, 32'h0000_1010)] = 32'hA000_0000;
        mem[key(0, 32'h0000_1110)] = 32'hA000_0001;
        mem[key(0, 32'h0000_1210)] = 32'hA000_0002;
        mem[key(0, 32'h0000_1310)] = 32'hA000_0003;
        mem[key(0, 32'h0000_1410)] = 32'hA000_0004;
        mem[key(0, 32'h0000_3030)] = 32'h0000_0000;
        mem[key(0, 32'h0000_4040)] = 32'hC0C0_C0C0;
        mem[key(0, 32'h0000_5050)] = 32'h5A5A_0001;
        mem[key(1, 32'h0000_2020)] = 32'hEEEE_0000;
        mem[key(1, 32'h0000_2120)] = 32'hB000_0001;
        mem[key(1, 32'h0000_2220)] = 32'hB000_0002;
        mem[key(1, 32'h0000_2320)] = 32'hB000_0003;
        mem[key(1, 32'h0000_2420)] = 32'hB000_0004;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_done_%0d", d),  32'(cpu_done[d]), 32'h0);
            chk($sformatf("rst_hit_%0d", d),   32'(hit[d]), 32'h0);
            chk($sformatf("rst_rdata_%0d", d), cpu_rdata[d], 32'h0);
            chk($sformatf("rst_mreq_%0d", d),  32'(mem_req[d]), 32'h0);
            chk($sformatf("rst_mwe_%0d", d),   32'(mem_we[d]), 32'h0);
            chk($sformatf("rst_maddr_%0d", d), mem_addr[d], 32'h0);
            chk($sformatf("rst_mwd_%0d", d),   mem_wdata[d], 32'h0);
        end
        reset = 2'b00;
        @(negedge clk);
        chk("ready_after_reset_0", 32'(cpu_ready[0]), 32'h1);
        chk("ready_after_reset_1", 32'(cpu_ready[1]), 32'h1);

        // Cold read then repeat hit.
        mlog.delete();
        req(0, 0, 32'h100, 0, 0, 1, 32'hDEAD_BEEF, "cold_read", lat);
        chk("cold_fill_count", mlog.size(), 1);
        chk_log("cold_fill", 0, 0, 32'h100, 32'hDEAD_BEEF);
        r0 = reqrise[0];
        req(0, 0, 32'h100, 0, 1, 1, 32'hDEAD_BEEF, "repeat_read", lat);
        chk("hit_latency", lat, 1);
        chk("hit_no_mem_req", reqrise[0], r0);

        // Write-through write hit.
        mlog.delete();
        req(0, 1, 32'h100, 32'h77, 1, 0, 0, "wt_write_hit", lat);
        chk("wt_hit_wr_count", mlog.size(), 1);
        chk_log("wt_hit_wr", 0, 1, 32'h100, 32'h77);
        req(0, 0, 32'h100, 0, 1, 1, 32'h77, "wt_hit_readback", lat);

        // Five reads into set 4; round-robin victim order.
        req(0, 0, 32'h1010, 0, 0, 1, 32'hA000_0000, "set_a0", lat);
        req(0, 0, 32'h1110, 0, 0, 1, 32'hA000_0001, "set_a1", lat);
        req(0, 0, 32'h1210, 0, 0, 1, 32'hA000_0002, "set_a2", lat);
        req(0, 0, 32'h1310, 0, 0, 1, 32'hA000_0003, "set_a3", lat);
        req(0, 0, 32'h1410, 0, 0, 1, 32'hA000_0004, "set_a4", lat);
        req(0, 0, 32'h1110, 0, 1, 1, 32'hA000_0001, "a1_still_hit", lat);
        req(0, 0, 32'h1010, 0, 0, 1, 32'hA000_0000, "a0_evicted", lat);
        req(0, 0, 32'h1110, 0, 0, 1, 32'hA000_0001, "rr_ptr_was_1", lat);

        // Write-back: dirty line evicted before the conflicting fill.
        req(1, 1, 32'h2020, 32'h11, 0, 0, 0, "wb_write_alloc", lat);
        req(1, 0, 32'h2120, 0, 0, 1, 32'hB000_0001, "wb_rd1", lat);
        req(1, 0, 32'h2220, 0, 0, 1, 32'hB000_0002, "wb_rd2", lat);
        req(1, 0, 32'h2320, 0, 0, 1, 32'hB000_0003, "wb_rd3", lat);
        mlog.delete();
        r0 = reqrise[1];
        req(1, 0, 32'h2420, 0, 0, 1, 32'hB000_0004, "wb_rd4", lat);
        chk("evict_fill_count", mlog.size(), 2);
        chk_log("evict_write", 0, 1, 32'h2020, 32'h11);
        chk_log("evict_then_fill", 1, 0, 32'h2420, 32'hB000_0004);
        chk("evict_fill_two_req_pulses", reqrise[1] - r0, 2);
        chk("evict_mem_content", mem[key(1, 32'h2020)], 32'h11);
        r0 = reqrise[1];
        req(1, 1, 32'h2120, 32'h22, 1, 0, 0, "wb_write_hit", lat);
        chk("wb_hit_latency", lat, 1);
        chk("wb_hit_no_mem_req", reqrise[1], r0);
        req(1, 0, 32'h2120, 0, 1, 1, 32'h22, "wb_hit_readback", lat);

        // Write-through write miss: no allocation.
        mlog.delete();
        req(0, 1, 32'h3030, 32'h55, 0, 0, 0, "wt_write_miss", lat);
        chk("wt_miss_wr_count", mlog.size(), 1);
        chk_log("wt_miss_wr", 0, 1, 32'h3030, 32'h55);
        req(0, 0, 32'h3030, 0, 0, 1, 32'h55, "no_alloc_read_miss", lat);

        // Reset during a stalled fill.
        stall[0] = 1;
        dc = donecnt[0];
        @(negedge clk);
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h4040;
        @(negedge clk);
        cpu_req[0] = 1'b0;
        n = 0;
        while (!mem_req[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fill_mem_req_up", 32'(mem_req[0]), 32'h1);
        chk("fill_mem_we_low", 32'(mem_we[0]), 32'h0);
        #2 reset[0] = 1'b1;
        #1 chk("reset_drops_mem_req", 32'(mem_req[0]), 32'h0);
        repeat (2) @(negedge clk);
        reset[0] = 1'b0;
        stall[0] = 0;
        repeat (5) @(negedge clk);
        chk("reset_no_done", donecnt[0] - dc, 0);
        req(0, 0, 32'h4040, 0, 0, 1, 32'hC0C0_C0C0, "after_abort_miss", lat);

        // cpu_req held for 10 cycles across a slow miss.
        mlat[0] = 14;
        begin
            exp_t e;
            e.inst = 0; e.hit = 0; e.chk = 1;
            e.rdata = 32'h5A5A_0001; e.name = "held_req";
            sb.push_back(e);
        end
        dc = donecnt[0];
        acc = 0;
        @(negedge clk);
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h5050;
        for (int i = 0; i < 10; i++) begin
            if (cpu_req[0] && cpu_ready[0]) acc++;
            @(negedge clk);
        end
        cpu_req[0] = 1'b0;
        n = 0;
        while (donecnt[0] == dc && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("held_req_accepts", acc, 1);
        chk("held_req_done_pulses", donecnt[0] - dc, 1);
        mlat[0] = 2;

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
